// File: rtl/iob_axi_ram_sched.sv
// rtl/iob_axi_ram_sched.sv - single-outstanding AXI4 scheduler for N_REQ native requesters
// Optional build macro: IOB_AXI_RAM_SCHED_FIXED_PRIO_EN (fixed priority, lowest index wins)
module iob_axi_ram_sched #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int LEN_WIDTH  = 8,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [N_REQ-1:0]              req_valid_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [N_REQ*STRB_WIDTH-1:0]   req_wstrb_i,
  output logic [N_REQ-1:0]              req_ready_o,
  output logic [N_REQ-1:0]              req_rvalid_o,
  output logic [DATA_WIDTH-1:0]         req_rdata_o,
  output logic [ID_WIDTH-1:0]           axi_awid_o,
  output logic [ADDR_WIDTH-1:0]         axi_awaddr_o,
  output logic [LEN_WIDTH-1:0]          axi_awlen_o,
  output logic [2:0]                    axi_awsize_o,
  output logic [1:0]                    axi_awburst_o,
  output logic                          axi_awvalid_o,
  input  logic                          axi_awready_i,
  output logic [DATA_WIDTH-1:0]         axi_wdata_o,
  output logic [STRB_WIDTH-1:0]         axi_wstrb_o,
  output logic                          axi_wlast_o,
  output logic                          axi_wvalid_o,
  input  logic                          axi_wready_i,
  input  logic [ID_WIDTH-1:0]           axi_bid_i,
  input  logic [1:0]                    axi_bresp_i,
  input  logic                          axi_bvalid_i,
  output logic                          axi_bready_o,
  output logic [ID_WIDTH-1:0]           axi_arid_o,
  output logic [ADDR_WIDTH-1:0]         axi_araddr_o,
  output logic [LEN_WIDTH-1:0]          axi_arlen_o,
  output logic [2:0]                    axi_arsize_o,
  output logic [1:0]                    axi_arburst_o,
  output logic                          axi_arvalid_o,
  input  logic                          axi_arready_i,
  input  logic [ID_WIDTH-1:0]           axi_rid_i,
  input  logic [DATA_WIDTH-1:0]         axi_rdata_i,
  input  logic [1:0]                    axi_rresp_i,
  input  logic                          axi_rlast_i,
  input  logic                          axi_rvalid_i,
  output logic                          axi_rready_o
);

  localparam int GW = $clog2(N_REQ);
  localparam logic [2:0] BEAT_SIZE = 3'($clog2(STRB_WIDTH));

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;

  state_t                  state, state_n;
  logic [GW-1:0]           grant;
  logic [GW-1:0]           pick;
  logic                    any_valid;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    aw_done, w_done;
  logic                    aw_hs, w_hs;
  logic                    busy;
  logic [N_REQ-1:0]        grant_onehot;

  // Response ids/status are not needed with a single outstanding transaction.
  logic unused_resp;
  assign unused_resp = ^{axi_bid_i, axi_bresp_i, axi_rid_i, axi_rresp_i, axi_rlast_i};

  assign any_valid = |req_valid_i;

`ifdef IOB_AXI_RAM_SCHED_FIXED_PRIO_EN
  // Fixed priority: lowest requester index that is asserting valid.
  always_comb begin
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) pick = GW'(i);
    end
  end
`else
  logic [GW-1:0] rr_ptr;
  logic          found;

  // Round-robin: first valid requester at or after the pointer, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid_i[(int'(rr_ptr) + i) % N_REQ]) begin
        pick  = GW'((int'(rr_ptr) + i) % N_REQ);
        found = 1'b1;
      end
    end
  end

  // Pointer moves just past the requester that was served.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rr_ptr <= '0;
    end else if (state == DONE) begin
      rr_ptr <= GW'((int'(grant) + 1) % N_REQ);
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_n;
  end

  // Next-state logic and handshake/completion outputs.
  always_comb begin
    state_n       = state;
    axi_awvalid_o = 1'b0;
    axi_wvalid_o  = 1'b0;
    axi_bready_o  = 1'b0;
    axi_arvalid_o = 1'b0;
    axi_rready_o  = 1'b0;
    req_ready_o   = '0;
    req_rvalid_o  = '0;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_n = (req_wstrb_i[int'(pick)*STRB_WIDTH +: STRB_WIDTH] != '0) ? WADDR : RADDR;
        end
      end
      WADDR: begin
        axi_awvalid_o = !aw_done;
        axi_wvalid_o  = !w_done;
        aw_hs = axi_awvalid_o && axi_awready_i;
        w_hs  = axi_wvalid_o && axi_wready_i;
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = WRESP;
      end
      WRESP: begin
        axi_bready_o = 1'b1;
        if (axi_bvalid_i) state_n = DONE;
      end
      RADDR: begin
        axi_arvalid_o = 1'b1;
        if (axi_arready_i) state_n = RDATA;
      end
      RDATA: begin
        axi_rready_o = 1'b1;
        if (axi_rvalid_i) state_n = DONE;
      end
      DONE: begin
        req_ready_o  = grant_onehot;
        req_rvalid_o = (wstrb_q == '0) ? grant_onehot : '0;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Latch the granted request in IDLE; track AW/W completion; capture read data.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      grant   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant   <= pick;
            addr_q  <= req_addr_i[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q <= req_wdata_i[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
            wstrb_q <= req_wstrb_i[int'(pick)*STRB_WIDTH +: STRB_WIDTH];
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        WADDR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        RDATA: begin
          if (axi_rvalid_i) rdata_q <= axi_rdata_i;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign grant_onehot = N_REQ'(1) << grant;

  // Payload comes straight from the latched request, so it is stable while valid.
  assign axi_awid_o    = ID_WIDTH'(grant);
  assign axi_arid_o    = ID_WIDTH'(grant);
  assign axi_awaddr_o  = addr_q;
  assign axi_araddr_o  = addr_q;
  assign axi_awlen_o   = '0;
  assign axi_arlen_o   = '0;
  assign axi_awsize_o  = busy ? BEAT_SIZE : 3'd0;
  assign axi_arsize_o  = busy ? BEAT_SIZE : 3'd0;
  assign axi_awburst_o = busy ? 2'b01 : 2'b00;
  assign axi_arburst_o = busy ? 2'b01 : 2'b00;
  assign axi_wdata_o   = wdata_q;
  assign axi_wstrb_o   = wstrb_q;
  assign axi_wlast_o   = busy;
  assign req_rdata_o   = rdata_q;

endmodule

// File: tb/tb_iob_axi_ram_sched.sv
// tb/tb_iob_axi_ram_sched.sv - scoreboard bench for iob_axi_ram_sched with an AXI RAM slave model
module tb_iob_axi_ram_sched;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int IW = 8;
  localparam int LW = 8;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*SW-1:0] req_wstrb = '0;
  logic [N-1:0]    req_ready, req_rvalid;
  logic [DW-1:0]   req_rdata;

  logic [IW-1:0] axi_awid, axi_arid;
  logic [AW-1:0] axi_awaddr, axi_araddr;
  logic [LW-1:0] axi_awlen, axi_arlen;
  logic [2:0]    axi_awsize, axi_arsize;
  logic [1:0]    axi_awburst, axi_arburst;
  logic          axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready;
  logic          axi_awready = 1'b0, axi_wready = 1'b0, axi_arready = 1'b0;
  logic [DW-1:0] axi_wdata;
  logic [SW-1:0] axi_wstrb;
  logic          axi_wlast;
  logic          axi_bvalid = 1'b0, axi_rvalid = 1'b0;
  logic [DW-1:0] axi_rdata = '0;

  iob_axi_ram_sched dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .req_ready_o(req_ready), .req_rvalid_o(req_rvalid), .req_rdata_o(req_rdata),
    .axi_awid_o(axi_awid), .axi_awaddr_o(axi_awaddr), .axi_awlen_o(axi_awlen),
    .axi_awsize_o(axi_awsize), .axi_awburst_o(axi_awburst),
    .axi_awvalid_o(axi_awvalid), .axi_awready_i(axi_awready),
    .axi_wdata_o(axi_wdata), .axi_wstrb_o(axi_wstrb), .axi_wlast_o(axi_wlast),
    .axi_wvalid_o(axi_wvalid), .axi_wready_i(axi_wready),
    .axi_bid_i('0), .axi_bresp_i(2'b00), .axi_bvalid_i(axi_bvalid), .axi_bready_o(axi_bready),
    .axi_arid_o(axi_arid), .axi_araddr_o(axi_araddr), .axi_arlen_o(axi_arlen),
    .axi_arsize_o(axi_arsize), .axi_arburst_o(axi_arburst),
    .axi_arvalid_o(axi_arvalid), .axi_arready_i(axi_arready),
    .axi_rid_i('0), .axi_rdata_i(axi_rdata), .axi_rresp_i(2'b00), .axi_rlast_i(1'b1),
    .axi_rvalid_i(axi_rvalid), .axi_rready_o(axi_rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int            req;
    bit            rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } op_t;

  exp_t sb[$];
  op_t  q0[$];
  op_t  q1[$];

  logic [DW-1:0] mem [0:255];
  int aw_delay = 0, r_delay = 0, aw_cnt = 0, r_cnt = 0;
  bit got_aw = 0, got_w = 0, b_pend = 0, r_pend = 0;
  logic [AW-1:0] aw_addr_l;
  logic [DW-1:0] w_data_l, r_data_l;
  logic [SW-1:0] w_strb_l;
  int resp_cyc = -10;
  exp_t e;
  logic [N-1:0] ev;
  op_t o0, o1;

  initial for (int i = 0; i < 256; i++) mem[i] = '0;

  // Slave model, scoreboard monitor and requester model, all evaluated mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      axi_awready = 0; axi_wready = 0; axi_arready = 0;
      axi_bvalid = 0; axi_rvalid = 0; axi_rdata = '0;
      got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0; aw_cnt = 0; r_cnt = 0;
    end else begin
      if (axi_awvalid) begin axi_awready = (aw_cnt >= aw_delay); aw_cnt++; end
      else begin axi_awready = 0; aw_cnt = 0; end
      axi_wready  = axi_wvalid;
      axi_arready = axi_arvalid;
      axi_bvalid  = b_pend;
      if (r_pend) begin axi_rvalid = (r_cnt >= r_delay); r_cnt++; end
      else axi_rvalid = 0;
      axi_rdata = axi_rvalid ? r_data_l : '0;

      if (axi_awvalid && axi_awready) begin
        got_aw = 1; aw_addr_l = axi_awaddr;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL aw_unexpected: AW handshake with empty scoreboard");
        end else if ({axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, sb[0].rd} !==
                     {IW'(sb[0].req), sb[0].addr, 8'h00, 3'd2, 2'd1, 1'b0}) begin
          miscompares++;
          $display("FAIL aw_payload: got id=%0h addr=%h len=%0d size=%0d burst=%0d, want id=%0d addr=%h len=0 size=2 burst=1 write=%0d",
                   axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, sb[0].req, sb[0].addr, !sb[0].rd);
        end
      end
      if (axi_wvalid && axi_wready) begin
        got_w = 1; w_data_l = axi_wdata; w_strb_l = axi_wstrb;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL w_unexpected: W handshake with empty scoreboard");
        end else if ({axi_wdata, axi_wstrb, axi_wlast} !== {sb[0].data, 4'hF, 1'b1}) begin
          miscompares++;
          $display("FAIL w_payload: got data=%h strb=%h last=%b, want data=%h strb=f last=1",
                   axi_wdata, axi_wstrb, axi_wlast, sb[0].data);
        end
      end
      if (axi_bvalid && axi_bready) begin b_pend = 0; resp_cyc = cyc; end
      if (axi_rvalid && axi_rready) begin r_pend = 0; r_cnt = 0; resp_cyc = cyc; end
      if (got_aw && got_w) begin
        for (int b = 0; b < SW; b++)
          if (w_strb_l[b]) mem[aw_addr_l[9:2]][b*8 +: 8] = w_data_l[b*8 +: 8];
        b_pend = 1; got_aw = 0; got_w = 0;
      end
      if (axi_arvalid && axi_arready) begin
        r_pend = 1; r_cnt = 0; r_data_l = mem[axi_araddr[9:2]];
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL ar_unexpected: AR handshake with empty scoreboard");
        end else if ({axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, sb[0].rd} !==
                     {IW'(sb[0].req), sb[0].addr, 8'h00, 3'd2, 2'd1, 1'b1}) begin
          miscompares++;
          $display("FAIL ar_payload: got id=%0h addr=%h len=%0d size=%0d burst=%0d, want id=%0d addr=%h len=0 size=2 burst=1 read=%0d",
                   axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, sb[0].req, sb[0].addr, sb[0].rd);
        end
      end
    end

    if (req_ready != '0 || req_rvalid != '0) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL completion_unexpected: ready=%b rvalid=%b with empty scoreboard", req_ready, req_rvalid);
      end else begin
        e  = sb.pop_front();
        ev = N'(1) << e.req;
        if ({req_ready, req_rvalid} !== {ev, (e.rd ? ev : N'(0))}) begin
          miscompares++;
          $display("FAIL completion_pulse: got ready=%b rvalid=%b, want ready=%b rvalid=%b",
                   req_ready, req_rvalid, ev, (e.rd ? ev : N'(0)));
        end
        vectors++;
        if (e.rd && req_rdata !== e.data) begin
          miscompares++;
          $display("FAIL completion_rdata: got %h, want %h", req_rdata, e.data);
        end
        vectors++;
        if (cyc !== resp_cyc + 1) begin
          miscompares++;
          $display("FAIL completion_latency: pulse at cycle %0d, want %0d", cyc, resp_cyc + 1);
        end
      end
    end

    if (rst_n) begin
      if (req_ready[0] && q0.size() > 0) void'(q0.pop_front());
      if (req_ready[1] && q1.size() > 0) void'(q1.pop_front());
    end
    o0 = (q0.size() > 0) ? q0[0] : '{default: '0};
    o1 = (q1.size() > 0) ? q1[0] : '{default: '0};
    req_valid = {q1.size() > 0, q0.size() > 0};
    req_addr  = {o1.addr, o0.addr};
    req_wdata = {o1.wdata, o0.wdata};
    req_wstrb = {o1.wstrb, o0.wstrb};
  end

  task automatic enq_op(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    op_t o;
    o.addr = a; o.wdata = d; o.wstrb = s;
    if (k == 0) q0.push_back(o);
    else        q1.push_back(o);
  endtask

  task automatic push_exp(input int k, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t x;
    x.req = k; x.rd = rd; x.addr = a; x.data = d;
    sb.push_back(x);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((sb.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL wait_done: %0d expectations still pending after %0d cycles, want 0", sb.size(), budget);
      sb.delete(); q0.delete(); q1.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    enq_op(0, 16'h0040, '0, '0);
    enq_op(1, 16'h0044, '0, '0);
    push_exp(0, 1, 16'h0040, 32'h0);
    push_exp(1, 1, 16'h0044, 32'h0);
    repeat (3) begin
      @(negedge clk); #1;
      vectors++;
      if ({req_ready, req_rvalid, req_rdata, axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready,
           axi_awaddr, axi_araddr, axi_awid, axi_arid, axi_awsize, axi_arsize, axi_awburst, axi_arburst,
           axi_wlast, axi_wdata, axi_wstrb} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: ready=%b rvalid=%b rdata=%h awv=%b wv=%b arv=%b araddr=%h arsize=%0d, want all 0",
                 req_ready, req_rvalid, req_rdata, axi_awvalid, axi_wvalid, axi_arvalid, axi_araddr, axi_arsize);
      end
    end
    rst_n = 1;
    vectors++;
    if (axi_arvalid !== 1'b0) begin
      miscompares++; $display("FAIL reset_release_arvalid: got %b, want 0", axi_arvalid);
    end
    @(negedge clk); #1;
    vectors++;
    if (axi_arvalid !== 1'b1) begin
      miscompares++; $display("FAIL first_arvalid: got %b, want 1 one cycle after release", axi_arvalid);
    end
    wait_done(50);
  endtask

  task automatic test_single_write();
    enq_op(0, 16'h0010, 32'hDEADBEEF, 4'hF);
    push_exp(0, 0, 16'h0010, 32'hDEADBEEF);
    wait_done(50);
  endtask

  task automatic test_read_back();
    enq_op(1, 16'h0010, '0, '0);
    push_exp(1, 1, 16'h0010, 32'hDEADBEEF);
    wait_done(50);
  endtask

  task automatic test_contention();
    enq_op(0, 16'h0020, 32'h11111111, 4'hF);
    enq_op(0, 16'h0024, 32'h22222222, 4'hF);
    enq_op(1, 16'h0010, '0, '0);
    enq_op(1, 16'h0020, '0, '0);
`ifdef IOB_AXI_RAM_SCHED_FIXED_PRIO_EN
    push_exp(0, 0, 16'h0020, 32'h11111111);
    push_exp(0, 0, 16'h0024, 32'h22222222);
    push_exp(1, 1, 16'h0010, 32'hDEADBEEF);
    push_exp(1, 1, 16'h0020, 32'h11111111);
`else
    push_exp(0, 0, 16'h0020, 32'h11111111);
    push_exp(1, 1, 16'h0010, 32'hDEADBEEF);
    push_exp(0, 0, 16'h0024, 32'h22222222);
    push_exp(1, 1, 16'h0020, 32'h11111111);
`endif
    wait_done(100);
  endtask

  task automatic test_backpressure();
    int n = 0;
    aw_delay = 3;
    enq_op(0, 16'h0030, 32'hCAFEF00D, 4'hF);
    push_exp(0, 0, 16'h0030, 32'hCAFEF00D);
    while (!axi_awvalid && n < 20) begin @(negedge clk); #1; n++; end
    vectors++;
    if (axi_wvalid !== 1'b1) begin
      miscompares++; $display("FAIL bp_wvalid_entry: got %b, want 1 at WADDR entry", axi_wvalid);
    end
    repeat (2) begin
      @(negedge clk); #1;
      vectors++;
      if ({axi_awvalid, axi_awaddr, axi_wvalid} !== {1'b1, 16'h0030, 1'b0}) begin
        miscompares++;
        $display("FAIL bp_hold: got awvalid=%b awaddr=%h wvalid=%b, want 1 0030 0", axi_awvalid, axi_awaddr, axi_wvalid);
      end
    end
    wait_done(50);
    aw_delay = 0;
    enq_op(1, 16'h0030, '0, '0);
    push_exp(1, 1, 16'h0030, 32'hCAFEF00D);
    wait_done(50);
  endtask

  task automatic test_reset_abort();
    int n = 0;
    r_delay = 20;
    enq_op(0, 16'h0010, '0, '0);
    push_exp(0, 1, 16'h0010, 32'hDEADBEEF);
    while (!axi_rready && n < 20) begin @(negedge clk); #1; n++; end
    rst_n = 0;
    q0.delete(); sb.delete();
    repeat (2) begin
      @(negedge clk); #1;
      vectors++;
      if ({req_ready, req_rvalid, axi_rready} !== '0) begin
        miscompares++;
        $display("FAIL abort_no_pulse: got ready=%b rvalid=%b rready=%b, want 0", req_ready, req_rvalid, axi_rready);
      end
    end
    rst_n = 1;
    r_delay = 0;
    enq_op(0, 16'h0010, '0, '0);
    push_exp(0, 1, 16'h0010, 32'hDEADBEEF);
    wait_done(50);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_back();
    test_contention();
    test_backpressure();
    test_reset_abort();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iob_axi_ram_sched.md
# iob_axi_ram_sched

Multi-requester scheduler in front of an AXI4 RAM slave. It arbitrates N_REQ native-interface requesters (valid/ready, write when wstrb≠0) and issues one single-beat AXI4 transaction at a time to the shared RAM. It returns write acknowledgements and read data to the granted requester. It sits between CPU/DMA-side native buses and `iob_axi_ram`.

## Interface
Parameters:
- N_REQ, 2, number of requesters (≥2)
- DATA_WIDTH, 32, data width; STRB_WIDTH = DATA_WIDTH/8
- ADDR_WIDTH, 16, byte address width
- ID_WIDTH, 8, AXI ID width (≥ $clog2(N_REQ))
- LEN_WIDTH, 8, AXI len width

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_n_i  in  1  reset, synchronous, active-low
- req_valid_i  in  N_REQ  per-requester request valid
- req_addr_i  in  N_REQ*ADDR_WIDTH  byte address, slice k = requester k
- req_wdata_i  in  N_REQ*DATA_WIDTH  write data
- req_wstrb_i  in  N_REQ*STRB_WIDTH  byte strobes; all-zero = read
- req_ready_o  out  N_REQ  one-cycle completion pulse
- req_rvalid_o  out  N_REQ  one-cycle read-data pulse
- req_rdata_o  out  DATA_WIDTH  read data, shared, valid with req_rvalid_o
- axi_awid_o / axi_awaddr_o / axi_awlen_o / axi_awsize_o / axi_awburst_o  out  ID/ADDR/LEN/3/2  AW payload
- axi_awvalid_o out 1; axi_awready_i in 1  AW handshake
- axi_wdata_o / axi_wstrb_o / axi_wlast_o  out  DATA/STRB/1  W payload
- axi_wvalid_o out 1; axi_wready_i in 1  W handshake
- axi_bid_i / axi_bresp_i  in  ID/2  B payload (bresp ignored)
- axi_bvalid_i in 1; axi_bready_o out 1  B handshake
- axi_arid_o / axi_araddr_o / axi_arlen_o / axi_arsize_o / axi_arburst_o  out  ID/ADDR/LEN/3/2  AR payload
- axi_arvalid_o out 1; axi_arready_i in 1  AR handshake
- axi_rid_i / axi_rdata_i / axi_rresp_i / axi_rlast_i  in  ID/DATA/2/1  R payload (rresp ignored)
- axi_rvalid_i in 1; axi_rready_o out 1  R handshake

## Operation
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, DONE. One outstanding transaction.
- IDLE: if any req_valid_i, register grant index g and the requester's addr/wdata/wstrb. Go to WADDR if wstrb≠0, else RADDR.
- Constant payload: len=0, size=$clog2(STRB_WIDTH), burst=2'b01 (INCR), wlast=1, id=g zero-extended.
- WADDR: awvalid and wvalid both asserted from state entry. Each drops independently after its own handshake. Go to WRESP when both are done (same-cycle completion allowed).
- WRESP: bready=1; on bvalid go to DONE.
- RADDR: arvalid=1 until arready, then RDATA.
- RDATA: rready=1; on rvalid capture rdata into req_rdata_o, then DONE.
- DONE: req_ready_o[g]=1 for one cycle; req_rvalid_o[g]=1 for reads. Update the round-robin pointer to g+1 mod N_REQ. Return to IDLE.
- Requesters hold valid and payload until their ready pulse. Address/data sampled in IDLE only.
- Round-robin: search starts at pointer, wraps at N_REQ-1→0. The pointer resets to 0.
- bid/rid are not checked; response order equals issue order.

## Timing
- Reset (rst_n_i low at edge): state IDLE, pointer 0. All valid/ready outputs 0, req_rdata_o 0, AXI payload outputs 0.
- Request seen in IDLE at cycle 0 → AXI valid asserted cycle 1.
- Write with a zero-wait slave: AW/W handshake cycle 1, bvalid cycle k → req_ready pulse cycle k+1.
- Read: rvalid handshake at cycle k → req_rvalid, req_ready and req_rdata at cycle k+1.
- Minimum gap between consecutive grants: 1 IDLE cycle after DONE.
- Requests arriving mid-transaction wait, and are not dropped.
- Simultaneous valids: exactly one grant per transaction.
- Reset mid-transaction aborts immediately with no completion pulse. The slave must be reset too.
- AXI valids never drop before their handshake; payload is stable while valid.

## Configuration
- IOB_AXI_RAM_SCHED_FIXED_PRIO_EN defined: fixed priority, lowest index wins. The pointer is not implemented.
- Undefined (default): round-robin as above.

## Test plan
- Reset: rst_n_i=0 for 3 cycles with valids high → all outputs 0, no AXI valid until 1 cycle after release.
- Single write: req0 addr 0x0010, wdata 0xDEADBEEF, wstrb 0xF. Expect AW addr 0x0010, id 0, len 0, size 2, burst 1; W data 0xDEADBEEF, wlast 1. req_ready_o[0] pulses one cycle after B.
- Read-back: req1 reads 0x0010 → AR id 1; req_rdata_o=0xDEADBEEF with req_rvalid_o[1] and req_ready_o[1] together.
- Contention: req0 and req1 hold valid for 4 transactions. Round-robin grants 0,1,0,1; with FIXED_PRIO_EN, req0 is served until it drops valid.
- Backpressure: awready delayed 3 cycles, wready immediate. Expect wvalid to drop after its handshake, awvalid held stable with payload, and completion only after B.
- Reset during RDATA, then a new req0 read → no pulse for the aborted read; the new read completes normally.
